csa_pipe_alu: RTL and testbench

Parametrised, pipelined carry-select adder/subtractor for the MIPS datapath. It replaces the fixed 32-bit combinational carry-select adder and adds:

- generic width and block size;
- an op field (ADD/SUB/SLT/SLTU);
- a two-stage register pipeline with valid/ready handshake on both sides.

It sits between the execute-stage operand muxes and writeback/branch-compare logic. It produces the sum plus carry, overflow, signed/unsigned less-than, zero and not-equal flags.

---
 rtl/csa_pkg.sv | 21 ++
 rtl/csa_dual_block.sv | 31 +++
 rtl/csa_pipe_alu.sv | 203 ++++++++++++++++++++
 tb/tb_csa_pipe_alu.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/csa_pkg.sv
// Shared definitions for the pipelined carry-select ALU: op encoding, default
// geometry and the geometry check used at elaboration.
package csa_pkg;

   typedef enum logic [1:0] {
      OP_ADD  = 2'b00,
      OP_SUB  = 2'b01,
      OP_SLT  = 2'b10,
      OP_SLTU = 2'b11
   } csa_op_e;

   localparam int CSA_WIDTH_DEF = 32;
   localparam int CSA_BLK_DEF   = 4;

   // Both the dual-candidate scheme and the top-block overflow pair need at
   // least two whole blocks.
   function automatic bit csa_geom_ok(input int width, input int blk);
      return (blk > 0) && ((width % blk) == 0) && (width >= 2 * blk);
   endfunction

endpackage

// File: rtl/csa_dual_block.sv
// BLK-bit adder slice producing the sum, carry-out and MSB overflow for both
// possible block carry-ins, so the select chain can pick one a stage later.
module csa_dual_block #(
   parameter int BLK = 4
) (
   input  logic [BLK-1:0] i_a,
   input  logic [BLK-1:0] i_b,
   output logic [BLK-1:0] o_sum0,
   output logic [BLK-1:0] o_sum1,
   output logic           o_c0,
   output logic           o_c1,
   output logic           o_ovf0,
   output logic           o_ovf1
);

   logic [BLK:0] w_full0;
   logic [BLK:0] w_full1;

   assign w_full0 = {1'b0, i_a} + {1'b0, i_b};
   assign w_full1 = w_full0 + (BLK+1)'(1);

   assign o_sum0 = w_full0[BLK-1:0];
   assign o_sum1 = w_full1[BLK-1:0];
   assign o_c0   = w_full0[BLK];
   assign o_c1   = w_full1[BLK];

   // Carry into the MSB is recovered from the MSB sum bit and its operands.
   assign o_ovf0 = (i_a[BLK-1] ^ i_b[BLK-1] ^ w_full0[BLK-1]) ^ w_full0[BLK];
   assign o_ovf1 = (i_a[BLK-1] ^ i_b[BLK-1] ^ w_full1[BLK-1]) ^ w_full1[BLK];

endmodule

// File: rtl/csa_pipe_alu.sv
// Two-stage pipelined carry-select add/sub/compare unit with valid/ready on
// both sides. Stage 1 registers per-block candidates, stage 2 resolves carries.
module csa_pipe_alu
   import csa_pkg::*;
#(
   parameter int WIDTH = CSA_WIDTH_DEF,
   parameter int BLK   = CSA_BLK_DEF
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   input  logic [1:0]       in_op,
   input  logic             in_cin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_result,
   output logic             out_cout,
   output logic             out_ovf,
   output logic             out_lt,
   output logic             out_ltu,
   output logic             out_zero,
   output logic             out_ne
);

   localparam int NBLK = WIDTH / BLK;

   typedef struct packed {
      logic [BLK-1:0] sum0;
      logic [BLK-1:0] sum1;
      logic           c0;
      logic           c1;
   } blk_rec_t;

   if (!csa_geom_ok(WIDTH, BLK)) begin : g_geom_chk
      $error("csa_pipe_alu: WIDTH must be a multiple of BLK and at least 2*BLK");
   end

   csa_op_e          w_op;
   logic [WIDTH-1:0] w_b_eff;
   logic             w_cin;
   logic [BLK-1:0]   w_sum0 [NBLK];
   logic [BLK-1:0]   w_sum1 [NBLK];
   logic             w_c0   [NBLK];
   logic             w_c1   [NBLK];
   logic             w_top_ovf0;
   logic             w_top_ovf1;
   logic             w_s1_load;
   logic             w_s2_load;
   logic             w_accept;

   logic             r_s1_valid;
   csa_op_e          r_s1_op;
   logic [BLK-1:0]   r_s1_b0_sum;
   logic             r_s1_b0_c;
   blk_rec_t         r_s1_blk [1:NBLK-1];
   logic             r_s1_ovf0;
   logic             r_s1_ovf1;

   logic             r_s2_valid;
   logic [WIDTH-1:0] r_s2_result;
   logic             r_s2_cout;
   logic             r_s2_ovf;
   logic             r_s2_lt;
   logic             r_s2_ltu;
   logic             r_s2_zero;
   logic             r_s2_ne;

   assign w_op    = csa_op_e'(in_op);
   assign w_b_eff = (w_op == OP_ADD) ? in_b : ~in_b;
   assign w_cin   = (w_op == OP_ADD) ? in_cin : 1'b1;

   for (genvar k = 0; k < NBLK; k++) begin : g_blk
      if (k == NBLK - 1) begin : g_top
         csa_dual_block #(.BLK(BLK)) u_blk (
            .i_a    (in_a[k*BLK +: BLK]),
            .i_b    (w_b_eff[k*BLK +: BLK]),
            .o_sum0 (w_sum0[k]),
            .o_sum1 (w_sum1[k]),
            .o_c0   (w_c0[k]),
            .o_c1   (w_c1[k]),
            .o_ovf0 (w_top_ovf0),
            .o_ovf1 (w_top_ovf1)
         );
      end else begin : g_low
         logic w_unused_ovf0;
         logic w_unused_ovf1;
         csa_dual_block #(.BLK(BLK)) u_blk (
            .i_a    (in_a[k*BLK +: BLK]),
            .i_b    (w_b_eff[k*BLK +: BLK]),
            .o_sum0 (w_sum0[k]),
            .o_sum1 (w_sum1[k]),
            .o_c0   (w_c0[k]),
            .o_c1   (w_c1[k]),
            .o_ovf0 (w_unused_ovf0),
            .o_ovf1 (w_unused_ovf1)
         );
      end
   end

   assign w_s2_load = ~r_s2_valid | out_ready;
   assign w_s1_load = ~r_s1_valid | w_s2_load;
   assign w_accept  = in_valid & w_s1_load;
   assign in_ready  = w_s1_load;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_s1_valid  <= 1'b0;
         r_s1_op     <= OP_ADD;
         r_s1_b0_sum <= '0;
         r_s1_b0_c   <= 1'b0;
         r_s1_ovf0   <= 1'b0;
         r_s1_ovf1   <= 1'b0;
         for (int k = 1; k < NBLK; k++) begin
            r_s1_blk[k] <= '0;
         end
      end else begin
         if (w_s1_load) begin
            r_s1_valid <= in_valid;
         end
         if (w_accept) begin
            r_s1_op     <= w_op;
            // Block 0 already knows its real carry-in, so only one candidate is kept.
            r_s1_b0_sum <= w_cin ? w_sum1[0] : w_sum0[0];
            r_s1_b0_c   <= w_cin ? w_c1[0] : w_c0[0];
            r_s1_ovf0   <= w_top_ovf0;
            r_s1_ovf1   <= w_top_ovf1;
            for (int k = 1; k < NBLK; k++) begin
               r_s1_blk[k] <= '{sum0: w_sum0[k], sum1: w_sum1[k], c0: w_c0[k], c1: w_c1[k]};
            end
         end
      end
   end

   logic [NBLK:1]    w_carry;
   logic [WIDTH-1:0] w_sum;
   logic             w_cout;
   logic             w_ovf;
   logic             w_lt;
   logic             w_ltu;
   logic             w_zero;
   logic [WIDTH-1:0] w_result;

   // w_carry[k] is the resolved carry into block k.
   always_comb begin
      w_carry          = '0;
      w_sum            = '0;
      w_carry[1]       = r_s1_b0_c;
      w_sum[BLK-1:0]   = r_s1_b0_sum;
      for (int k = 1; k < NBLK; k++) begin
         w_sum[k*BLK +: BLK] = w_carry[k] ? r_s1_blk[k].sum1 : r_s1_blk[k].sum0;
         w_carry[k+1]        = w_carry[k] ? r_s1_blk[k].c1 : r_s1_blk[k].c0;
      end
      w_cout = w_carry[NBLK];
      w_ovf  = w_carry[NBLK-1] ? r_s1_ovf1 : r_s1_ovf0;
      w_lt   = w_sum[WIDTH-1] ^ w_ovf;
      w_ltu  = ~w_cout;
      w_zero = (w_sum == '0);
      case (r_s1_op)
         OP_SLT:  w_result = {{(WIDTH-1){1'b0}}, w_lt};
         OP_SLTU: w_result = {{(WIDTH-1){1'b0}}, w_ltu};
         default: w_result = w_sum;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_s2_valid  <= 1'b0;
         r_s2_result <= '0;
         r_s2_cout   <= 1'b0;
         r_s2_ovf    <= 1'b0;
         r_s2_lt     <= 1'b0;
         r_s2_ltu    <= 1'b0;
         r_s2_zero   <= 1'b0;
         r_s2_ne     <= 1'b0;
      end else begin
         if (w_s2_load) begin
            r_s2_valid <= r_s1_valid;
         end
         if (w_s2_load && r_s1_valid) begin
            r_s2_result <= w_result;
            r_s2_cout   <= w_cout;
            r_s2_ovf    <= w_ovf;
            r_s2_lt     <= w_lt;
            r_s2_ltu    <= w_ltu;
            r_s2_zero   <= w_zero;
            r_s2_ne     <= ~w_zero;
         end
      end
   end

   assign out_valid  = r_s2_valid;
   assign out_result = r_s2_result;
   assign out_cout   = r_s2_cout;
   assign out_ovf    = r_s2_ovf;
   assign out_lt     = r_s2_lt;
   assign out_ltu    = r_s2_ltu;
   assign out_zero   = r_s2_zero;
   assign out_ne     = r_s2_ne;

endmodule

// File: tb/tb_csa_pipe_alu.sv
// Bench for csa_pipe_alu: directed corner cases plus randomized traffic with
// random backpressure, scored against an arithmetic reference model.
module tb_csa_pipe_alu;

   logic        clk;
   logic        rst_n;

   logic        in_valid, in_ready, in_cin, out_valid, out_ready;
   logic [31:0] in_a, in_b, out_result;
   logic [1:0]  in_op;
   logic        out_cout, out_ovf, out_lt, out_ltu, out_zero, out_ne;

   logic        in_valid16, in_ready16, in_cin16, out_valid16, out_ready16;
   logic [15:0] in_a16, in_b16, out_result16;
   logic [1:0]  in_op16;
   logic        out_cout16, out_ovf16, out_lt16, out_ltu16, out_zero16, out_ne16;

   logic [5:0]  fl32, fl16;
   assign fl32 = {out_cout, out_ovf, out_lt, out_ltu, out_zero, out_ne};
   assign fl16 = {out_cout16, out_ovf16, out_lt16, out_ltu16, out_zero16, out_ne16};

   csa_pipe_alu #(.WIDTH(32), .BLK(4)) u_dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_a(in_a), .in_b(in_b), .in_op(in_op), .in_cin(in_cin),
      .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
      .out_cout(out_cout), .out_ovf(out_ovf), .out_lt(out_lt),
      .out_ltu(out_ltu), .out_zero(out_zero), .out_ne(out_ne)
   );

   csa_pipe_alu #(.WIDTH(16), .BLK(4)) u_dut16 (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid16), .in_ready(in_ready16),
      .in_a(in_a16), .in_b(in_b16), .in_op(in_op16), .in_cin(in_cin16),
      .out_valid(out_valid16), .out_ready(out_ready16), .out_result(out_result16),
      .out_cout(out_cout16), .out_ovf(out_ovf16), .out_lt(out_lt16),
      .out_ltu(out_ltu16), .out_zero(out_zero16), .out_ne(out_ne16)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_vec  = 0;
   int n_chk  = 0;
   int n_miss = 0;
   int n_out  = 0;

   typedef struct {
      logic [63:0] res;
      logic [5:0]  fl;
   } exp_t;
   exp_t q[$];

   // Reference: w-bit two's-complement add of a and b' with carry-in, flags
   // derived from the true sum, result picked by op.
   function automatic void model(input int w, input logic [63:0] a, input logic [63:0] b,
                                 input logic [1:0] op, input logic cin,
                                 output logic [63:0] res, output logic [5:0] fl);
      logic [63:0] mask, bb, full, s;
      logic        c, cout, ovf, lt, ltu, zero, sa, sb, ss;
      mask = (64'd1 << w) - 64'd1;
      bb   = (op == 2'd0) ? (b & mask) : (~b & mask);
      c    = (op == 2'd0) ? cin : 1'b1;
      full = (a & mask) + bb + {63'd0, c};
      s    = full & mask;
      cout = full[w];
      sa   = a[w-1];
      sb   = bb[w-1];
      ss   = s[w-1];
      ovf  = (sa == sb) && (ss != sa);
      lt   = ss ^ ovf;
      ltu  = ~cout;
      zero = (s == 64'd0);
      case (op)
         2'd2:    res = {63'd0, lt};
         2'd3:    res = {63'd0, ltu};
         default: res = s;
      endcase
      fl = {cout, ovf, lt, ltu, zero, ~zero};
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_miss++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Scoreboard: outputs are checked and inputs captured on the falling edge,
   // i.e. for the transfers that the next rising edge will commit.
   always @(negedge clk) begin
      if (!rst_n) begin
         q.delete();
      end else begin
         if (out_valid && out_ready) begin
            exp_t e;
            n_out++;
            n_chk++;
            assert (q.size() != 0) else begin
               n_miss++;
               $error("FAIL sb_extra: observed beat %0h expected none", out_result);
            end
            if (q.size() != 0) begin
               e = q.pop_front();
               chk("sb_result", 64'(out_result), e.res);
               chk("sb_flags", 64'(fl32), 64'(e.fl));
            end
         end
         if (in_valid && in_ready) begin
            exp_t e;
            model(32, 64'(in_a), 64'(in_b), in_op, in_cin, e.res, e.fl);
            q.push_back(e);
            n_vec++;
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: observed no end of run expected finish");
      $fatal(1, "watchdog expired");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [31:0] a, input logic [31:0] b, input logic [1:0] op, input logic cin);
      in_valid = 1'b1;
      in_a     = a;
      in_b     = b;
      in_op    = op;
      in_cin   = cin;
   endtask

   // One beat into an otherwise empty pipe; result must show after two edges.
   task automatic single(input logic [31:0] a, input logic [31:0] b, input logic [1:0] op, input logic cin);
      drive(a, b, op, cin);
      chk("lat_in_ready", 64'(in_ready), 64'd1);
      tick();
      in_valid = 1'b0;
      chk("lat_edge1_valid", 64'(out_valid), 64'd0);
      tick();
      chk("lat_edge2_valid", 64'(out_valid), 64'd1);
   endtask

   function automatic logic [31:0] pick32();
      logic [31:0] corners [4];
      corners[0] = 32'hFFFF_FFFF;
      corners[1] = 32'h7FFF_FFFF;
      corners[2] = 32'h8000_0000;
      corners[3] = 32'h0000_0000;
      if ($urandom_range(0, 3) == 0) return corners[$urandom_range(0, 3)];
      return $urandom;
   endfunction

   initial begin
      logic [63:0] er;
      logic [5:0]  ef;
      int          out0;
      int          guard;

      rst_n = 1'b0;
      in_valid = 1'b0; in_a = '0; in_b = '0; in_op = 2'd0; in_cin = 1'b0; out_ready = 1'b0;
      in_valid16 = 1'b0; in_a16 = '0; in_b16 = '0; in_op16 = 2'd0; in_cin16 = 1'b0; out_ready16 = 1'b1;
      repeat (3) tick();
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_result", 64'(out_result), 64'd0);
      chk("rst_flags", 64'(fl32), 64'd0);
      rst_n = 1'b1;
      chk("rst_in_ready", 64'(in_ready), 64'd1);
      out_ready = 1'b1;

      single(32'h7FFF_FFFF, 32'h0000_0001, 2'd0, 1'b0);
      chk("add_ovf_result", 64'(out_result), 64'h8000_0000);
      chk("add_ovf_ovf", 64'(out_ovf), 64'd1);
      chk("add_ovf_cout", 64'(out_cout), 64'd0);
      chk("add_ovf_ne", 64'(out_ne), 64'd1);
      model(32, 64'h7FFF_FFFF, 64'h1, 2'd0, 1'b0, er, ef);
      chk("add_ovf_flags", 64'(fl32), 64'(ef));

      single(32'h5, 32'h5, 2'd1, 1'b0);
      chk("sub_eq_result", 64'(out_result), 64'd0);
      chk("sub_eq_zero", 64'(out_zero), 64'd1);
      chk("sub_eq_ne", 64'(out_ne), 64'd0);
      chk("sub_eq_cout", 64'(out_cout), 64'd1);
      chk("sub_eq_ltu", 64'(out_ltu), 64'd0);
      chk("sub_eq_ovf", 64'(out_ovf), 64'd0);

      single(32'hFFFF_FFFF, 32'h1, 2'd2, 1'b0);
      chk("slt_result", 64'(out_result), 64'd1);
      single(32'hFFFF_FFFF, 32'h1, 2'd3, 1'b0);
      chk("sltu_result", 64'(out_result), 64'd0);
      single(32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'd0, 1'b1);
      chk("add_wrap_result", 64'(out_result), 64'hFFFF_FFFF);
      chk("add_wrap_cout", 64'(out_cout), 64'd1);
      tick();

      // Backpressure: two beats fill the pipe, the third waits for release.
      out_ready = 1'b0;
      out0 = n_out;
      drive(32'd10, 32'd3, 2'd0, 1'b0);
      tick();
      drive(32'd20, 32'd7, 2'd1, 1'b0);
      chk("bp_ready_after1", 64'(in_ready), 64'd1);
      tick();
      drive(32'd30, 32'd40, 2'd2, 1'b0);
      chk("bp_ready_after2", 64'(in_ready), 64'd0);
      tick();
      chk("bp_ready_held", 64'(in_ready), 64'd0);
      chk("bp_out_held", 64'(out_result), 64'd13);
      out_ready = 1'b1;
      #1;
      chk("bp_ready_release", 64'(in_ready), 64'd1);
      tick();
      in_valid = 1'b0;
      tick();
      tick();
      chk("bp_beats_out", 64'(n_out - out0), 64'd3);
      chk("bp_sb_empty", 64'(q.size()), 64'd0);

      // Reset with two beats in flight.
      out_ready = 1'b0;
      drive(32'h1234, 32'h1, 2'd0, 1'b0);
      tick();
      drive(32'h5678, 32'h2, 2'd1, 1'b0);
      tick();
      in_valid = 1'b0;
      chk("midrst_full", 64'(in_ready), 64'd0);
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      chk("midrst_out_valid", 64'(out_valid), 64'd0);
      chk("midrst_result", 64'(out_result), 64'd0);
      chk("midrst_flags", 64'(fl32), 64'd0);
      chk("midrst_in_ready", 64'(in_ready), 64'd1);
      out_ready = 1'b1;
      tick();
      tick();
      chk("midrst_no_ghost", 64'(out_valid), 64'd0);

      // Randomized traffic with random stalls.
      for (int i = 0; i < 400; i++) begin
         in_valid  = ($urandom_range(0, 9) < 7);
         in_a      = pick32();
         in_b      = pick32();
         in_op     = 2'($urandom_range(0, 3));
         in_cin    = 1'($urandom_range(0, 1));
         out_ready = ($urandom_range(0, 9) < 7);
         tick();
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      guard = 0;
      while (q.size() != 0 && guard < 20) begin
         tick();
         guard++;
      end
      chk("drain_empty", 64'(q.size()), 64'd0);

      // 16-bit instance.
      in_valid16 = 1'b1; in_a16 = 16'hFFFF; in_b16 = 16'h0001; in_op16 = 2'd0; in_cin16 = 1'b0;
      tick();
      in_valid16 = 1'b0;
      tick();
      chk("w16_valid", 64'(out_valid16), 64'd1);
      chk("w16_result", 64'(out_result16), 64'd0);
      chk("w16_cout", 64'(out_cout16), 64'd1);
      chk("w16_zero", 64'(out_zero16), 64'd1);
      chk("w16_ovf", 64'(out_ovf16), 64'd0);
      n_vec++;
      for (int i = 0; i < 24; i++) begin
         in_valid16 = 1'b1;
         in_a16     = 16'($urandom);
         in_b16     = 16'($urandom);
         in_op16    = 2'($urandom_range(0, 3));
         in_cin16   = 1'($urandom_range(0, 1));
         model(16, 64'(in_a16), 64'(in_b16), in_op16, in_cin16, er, ef);
         n_vec++;
         tick();
         in_valid16 = 1'b0;
         tick();
         chk("w16r_valid", 64'(out_valid16), 64'd1);
         chk("w16r_result", 64'(out_result16), er);
         chk("w16r_flags", 64'(fl16), 64'(ef));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
